// File: rtl/irqctl.sv
// Interrupt controller: latches level/edge requests, masks them with ENABLE,
// drives a registered irq and exposes PEND/ENABLE/CLAIM/MASKED on the data bus.
module irqctl #(
  parameter int unsigned N    = 8,
  parameter logic [N-1:0] EDGE = '0,
  parameter int unsigned X1   = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  irq_in,
  input  logic          sel,
  input  logic          re,
  input  logic          we,
  input  logic [1:0]    addr,
  input  logic [X1:0]   din,
  output logic [X1:0]   dout,
  output logic          irq
);

  localparam int unsigned DW  = X1 + 1;
  localparam int unsigned IDW = $clog2(N + 1);

  localparam logic [1:0] A_PEND   = 2'd0;
  localparam logic [1:0] A_ENABLE = 2'd1;
  localparam logic [1:0] A_CLAIM  = 2'd2;
  localparam logic [1:0] A_MASKED = 2'd3;

  logic [N-1:0]   pend, pend_nxt;
  logic [N-1:0]   enable, enable_nxt;
  logic [N-1:0]   prev;
  logic [N-1:0]   masked;
  logic [N-1:0]   claim_oh;
  logic [N-1:0]   clr;
  logic [IDW-1:0] claim_id;
  logic [DW-1:0]  rdata;
  logic           rd_en, wr_en;
  logic           unused_din;

  // Upper data bits beyond N are intentionally ignored on writes.
  assign unused_din = ^din;

  assign rd_en  = sel & re;
  assign wr_en  = sel & we;
  assign masked = pend & enable;

  // Fixed priority: the lowest pending+enabled index wins.
  always_comb begin
    claim_id = '0;
    claim_oh = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (masked[i]) begin
        claim_id    = IDW'(i + 1);
        claim_oh    = '0;
        claim_oh[i] = 1'b1;
      end
    end
  end

  // Next-state for PEND/ENABLE; a new rising edge beats a same-cycle clear.
  always_comb begin
    clr        = '0;
    enable_nxt = enable;
    if (wr_en && addr == A_PEND)
      clr = clr | din[N-1:0];
    if (rd_en && addr == A_CLAIM)
      clr = clr | claim_oh;
    clr = clr & EDGE;
    if (wr_en && addr == A_ENABLE)
      enable_nxt = din[N-1:0];
    pend_nxt = (EDGE & ((pend & ~clr) | (irq_in & ~prev))) | (~EDGE & irq_in);
  end

  // Read mux over the pre-edge state.
  always_comb begin
    rdata = '0;
    case (addr)
      A_PEND:   rdata = DW'(pend);
      A_ENABLE: rdata = DW'(enable);
      A_CLAIM:  rdata = DW'(claim_id);
      A_MASKED: rdata = DW'(masked);
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev   <= '0;
      pend   <= '0;
      enable <= '0;
      irq    <= 1'b0;
      dout   <= '0;
    end else begin
      prev   <= irq_in;
      pend   <= pend_nxt;
      enable <= enable_nxt;
      irq    <= |masked;
      if (rd_en)
        dout <= rdata;
    end
  end

endmodule

// File: tb/tb_irqctl.sv
// Directed bench for irqctl: N=8, sources 0 and 1 edge-triggered, the rest level.
module tb_irqctl;

  localparam int unsigned N  = 8;
  localparam int unsigned X1 = 31;

  logic          clk;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          sel, re, we;
  logic [1:0]    addr;
  logic [X1:0]   din;
  logic [X1:0]   dout;
  logic          irq;

  int n_cmp;
  int n_err;

  irqctl #(.N(N), .EDGE(8'h03), .X1(X1)) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .sel    (sel),
    .re     (re),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample/drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    sel = 1'b1; re = 1'b1; we = 1'b0; addr = a;
    tick();
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; re = 1'b0; we = 1'b1; addr = a; din = d;
    tick();
    sel = 1'b0; we = 1'b0; din = '0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; irq_in = 8'hFF;
    sel = 1'b0; re = 1'b0; we = 1'b0; addr = 2'd0; din = '0;

    // Reset with all inputs high
    tick(); tick();
    chk("rst_dout", dout, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    tick();
    rd(2'd0);
    chk("post_rst_pend", dout, 32'hFF);
    chk("post_rst_irq", 32'(irq), 32'h0);
    irq_in = 8'h00;
    wr(2'd0, 32'h03);
    rd(2'd0);
    chk("pend_cleared", dout, 32'h00);

    // Level source 2
    wr(2'd1, 32'h04);
    irq_in[2] = 1'b1;
    tick();
    chk("lvl_irq_edge1", 32'(irq), 32'h0);
    tick();
    chk("lvl_irq_edge2", 32'(irq), 32'h1);
    rd(2'd2);
    chk("lvl_claim", dout, 32'h3);
    irq_in[2] = 1'b0;
    tick();
    chk("lvl_drop_edge1", 32'(irq), 32'h1);
    tick();
    chk("lvl_drop_edge2", 32'(irq), 32'h0);
    chk("dout_hold", dout, 32'h3);

    // Edge source 0 with claim
    wr(2'd1, 32'h01);
    irq_in[0] = 1'b1;
    tick();
    irq_in[0] = 1'b0;
    tick();
    chk("edge_irq", 32'(irq), 32'h1);
    rd(2'd0);
    chk("edge_pend", dout, 32'h01);
    rd(2'd2);
    chk("edge_claim", dout, 32'h1);
    chk("edge_irq_after_claim", 32'(irq), 32'h1);
    rd(2'd0);
    chk("edge_pend_cleared", dout, 32'h00);
    chk("edge_irq_fall", 32'(irq), 32'h0);
    rd(2'd2);
    chk("edge_claim_empty", dout, 32'h0);

    // Priority among level sources 3 and 5
    wr(2'd1, 32'hFF);
    irq_in = 8'h28;
    tick();
    rd(2'd2);
    chk("prio_claim_3", dout, 32'h4);
    irq_in[3] = 1'b0;
    tick();
    rd(2'd2);
    chk("prio_claim_5", dout, 32'h6);
    wr(2'd1, 32'h00);
    chk("prio_irq_at_wr", 32'(irq), 32'h1);
    tick();
    chk("prio_irq_masked", 32'(irq), 32'h0);
    rd(2'd3);
    chk("prio_masked", dout, 32'h0);
    irq_in = 8'h00;
    tick();

    // Upper ENABLE bits and read/write collision
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1);
    chk("enable_width", dout, 32'hFF);
    sel = 1'b1; re = 1'b1; we = 1'b1; addr = 2'd1; din = 32'h55;
    tick();
    sel = 1'b0; re = 1'b0; we = 1'b0; din = '0;
    chk("rw_collide_read", dout, 32'hFF);
    rd(2'd1);
    chk("rw_collide_write", dout, 32'h55);

    // Edge source 1: W1C colliding with a new rising edge
    irq_in[1] = 1'b1;
    tick();
    irq_in[1] = 1'b0;
    tick();
    rd(2'd0);
    chk("col_pend_before", dout, 32'h02);
    sel = 1'b1; we = 1'b1; addr = 2'd0; din = 32'h02; irq_in[1] = 1'b1;
    tick();
    sel = 1'b0; we = 1'b0; din = '0; irq_in[1] = 1'b0;
    rd(2'd0);
    chk("col_set_wins", dout, 32'h02);
    wr(2'd0, 32'h02);
    rd(2'd0);
    chk("w1c_plain", dout, 32'h00);

    // Async reset in the middle of a claim read
    wr(2'd1, 32'h04);
    irq_in[2] = 1'b1;
    tick(); tick();
    rd(2'd2);
    chk("pre_rst_claim", dout, 32'h3);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    sel = 1'b1; re = 1'b1; addr = 2'd2;
    #2;
    rst = 1'b1;
    #1;
    chk("async_dout", dout, 32'h0);
    chk("async_irq", 32'(irq), 32'h0);
    chk("async_pend", 32'(dut.pend), 32'h0);
    chk("async_enable", 32'(dut.enable), 32'h0);
    sel = 1'b0; re = 1'b0; irq_in = 8'h00;
    tick();
    rst = 1'b0;
    tick();
    rd(2'd1);
    chk("post_async_enable", dout, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
